// File: rtl/ltc2324_pkg.sv
// Shared types and constants for the LTC2324-16 device-side emulator.
// Test pattern feature is enabled with LTC2324_EMU_TESTPATTERN_EN.
package ltc2324_pkg;

    localparam int NBITS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        READY,
        DONE
    } state_e;

    localparam logic [15:0] PAT_CH1 = 16'h1234;
    localparam logic [15:0] PAT_CH4 = 16'h5678;

endpackage

// File: rtl/ltc2324_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with
// single-cycle rise/fall pulses on the synchronized level.
module ltc2324_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ltc2324_16_emu.sv
// LTC2324-16 quad serial ADC emulator driven by oversampled CNV/SCK.
// Define LTC2324_EMU_TESTPATTERN_EN to replace ch*_in with internal patterns.
module ltc2324_16_emu
    import ltc2324_pkg::*;
#(
    parameter int T_CONV_CYC  = 24,
    parameter int NBITS       = NBITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CNV,
    input  logic        SCK,
    input  logic [15:0] ch1_in,
    input  logic [15:0] ch2_in,
    input  logic [15:0] ch3_in,
    input  logic [15:0] ch4_in,
    output logic        SDO1,
    output logic        SDO2,
    output logic        SDO3,
    output logic        SDO4,
    output logic        CLKOUT,
    output logic        busy,
    output logic        overrun
);

    localparam int CW = $clog2(T_CONV_CYC + 1);
    localparam int BW = $clog2(NBITS + 1);

    logic cnv_rise, cnv_lvl_unused, cnv_fall_unused;
    logic sck_lvl, sck_fall, sck_rise_unused;
    logic accept;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [3:0][NBITS-1:0]   sr_q, sr_d;
    logic                    ovr_q, ovr_d;
    logic                    clkout_q;
    logic [3:0][15:0]        smp;

    ltc2324_sync_edge #(.STAGES(SYNC_STAGES)) u_cnv (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (CNV),
        .level_o (cnv_lvl_unused),
        .rise_o  (cnv_rise),
        .fall_o  (cnv_fall_unused)
    );

    ltc2324_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (SCK),
        .level_o (sck_lvl),
        .rise_o  (sck_rise_unused),
        .fall_o  (sck_fall)
    );

    // A CNV rise during CONV is not a new conversion, only an overrun.
    assign accept = cnv_rise && (state_q != CONV);

`ifdef LTC2324_EMU_TESTPATTERN_EN
    logic [15:0] pat2_q, pat3_q, pat2_nx, pat3_nx;
    logic        unused_ch;

    assign pat2_nx   = pat2_q + 16'd1;
    assign pat3_nx   = {pat3_q[14:0], 1'b1};
    assign unused_ch = ^{ch1_in, ch2_in, ch3_in, ch4_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat2_q <= '0;
            pat3_q <= '0;
        end else if (accept) begin
            pat2_q <= pat2_nx;
            pat3_q <= pat3_nx;
        end
    end

    assign smp = {PAT_CH4, pat3_nx, pat2_nx, PAT_CH1};
`else
    assign smp = {ch4_in, ch3_in, ch2_in, ch1_in};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
            ovr_q    <= 1'b0;
            clkout_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            ovr_q    <= ovr_d;
            clkout_q <= sck_lvl;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            CONV: begin
                if (cnv_rise) ovr_d = 1'b1;
                if (cnt_q == '0) state_d = READY;
                else cnt_d = cnt_q - CW'(1);
            end
            READY: begin
                if (sck_fall) begin
                    for (int i = 0; i < 4; i++)
                        sr_d[i] = {sr_q[i][NBITS-2:0], 1'b0};
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BW'(NBITS - 1)) state_d = DONE;
                end
            end
            default: ;
        endcase
        // Placed last so a new conversion beats a same-cycle shift.
        if (accept) begin
            state_d = CONV;
            cnt_d   = CW'(T_CONV_CYC - 1);
            bit_d   = '0;
            for (int i = 0; i < 4; i++)
                sr_d[i] = NBITS'(smp[i]);
        end
    end

    assign SDO1    = (state_q == READY) & sr_q[0][NBITS-1];
    assign SDO2    = (state_q == READY) & sr_q[1][NBITS-1];
    assign SDO3    = (state_q == READY) & sr_q[2][NBITS-1];
    assign SDO4    = (state_q == READY) & sr_q[3][NBITS-1];
    assign CLKOUT  = clkout_q;
    assign busy    = (state_q == CONV);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_ltc2324_16_emu.sv
// Directed bench for ltc2324_16_emu: conversion timing, readout,
// overrun, abort, overlong SCK bursts and mid-frame reset.
module tb_ltc2324_16_emu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CNV = 1'b0;
    logic        SCK = 1'b0;
    logic [15:0] ch1_in = '0;
    logic [15:0] ch2_in = '0;
    logic [15:0] ch3_in = '0;
    logic [15:0] ch4_in = '0;
    logic        SDO1, SDO2, SDO3, SDO4;
    logic        CLKOUT, busy, overrun;

    int          n_tests = 0;
    int          n_fail = 0;
    int          rises = 0;
    logic [15:0] exp_w [4];
    logic [15:0] m2 = '0;
    logic [15:0] m3 = '0;
    logic [31:0] got [4];
    wire  [3:0]  sdo = {SDO4, SDO3, SDO2, SDO1};

    always #5 clk = ~clk;
    always @(posedge CLKOUT) rises++;

    ltc2324_16_emu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .CNV     (CNV),
        .SCK     (SCK),
        .ch1_in  (ch1_in),
        .ch2_in  (ch2_in),
        .ch3_in  (ch3_in),
        .ch4_in  (ch4_in),
        .SDO1    (SDO1),
        .SDO2    (SDO2),
        .SDO3    (SDO3),
        .SDO4    (SDO4),
        .CLKOUT  (CLKOUT),
        .busy    (busy),
        .overrun (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic latch_model();
`ifdef LTC2324_EMU_TESTPATTERN_EN
        m2 = m2 + 16'd1;
        m3 = {m3[14:0], 1'b1};
        exp_w[0] = 16'h1234;
        exp_w[1] = m2;
        exp_w[2] = m3;
        exp_w[3] = 16'h5678;
`else
        exp_w[0] = ch1_in;
        exp_w[1] = ch2_in;
        exp_w[2] = ch3_in;
        exp_w[3] = ch4_in;
`endif
    endtask

    task automatic set_ch(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
        ch1_in = a;
        ch2_in = b;
        ch3_in = c;
        ch4_in = d;
    endtask

    // CNV pulse; optional second pulse inside CONV with changed inputs.
    task automatic do_conv(input bit dbl, input logic [15:0] alt,
                           input string tag);
        int lat;
        int width;
        lat = -1;
        width = 0;
        latch_model();
        CNV = 1'b1;
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            if (t == 4) CNV = 1'b0;
            if (dbl && t == 6) set_ch(alt, alt, alt, alt);
            if (dbl && t == 12) CNV = 1'b1;
            if (dbl && t == 16) CNV = 1'b0;
            if (busy) begin
                if (lat < 0) lat = t;
                width++;
            end else if (lat >= 0) begin
                break;
            end
        end
        check({tag, " busy latency"}, lat, 3);
        check({tag, " busy width"}, width, 24);
        check({tag, " first msb"}, {28'h0, sdo},
              {28'h0, exp_w[3][15], exp_w[2][15], exp_w[1][15], exp_w[0][15]});
        repeat (2) @(negedge clk);
    endtask

    task automatic shift_bits(input int n);
        for (int i = 0; i < 4; i++) got[i] = '0;
        for (int b = 0; b < n; b++) begin
            SCK = 1'b1;
            repeat (4) @(negedge clk);
            for (int i = 0; i < 4; i++) got[i] = {got[i][30:0], sdo[i]};
            SCK = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input int n);
        logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            e = {exp_w[i], 16'h0} >> (32 - n);
            check($sformatf("%s ch%0d", tag, i + 1), got[i], e);
        end
    endtask

    initial begin
        int r0;
        repeat (2) @(negedge clk);
        check("reset sdo", {28'h0, sdo}, 32'h0);
        check("reset clkout", {31'h0, CLKOUT}, 32'h0);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset overrun", {31'h0, overrun}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        set_ch(16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF);
        do_conv(1'b0, 16'h0, "f1");
        shift_bits(16);
        check_frame("f1", 16);
        check("f1 sdo idle after 16", {28'h0, sdo}, 32'h0);
        check("f1 overrun", {31'h0, overrun}, 32'h0);

        set_ch(16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0);
        do_conv(1'b1, 16'h0F0F, "ovr");
        check("ovr flag", {31'h0, overrun}, 32'h1);
        shift_bits(16);
        check_frame("ovr", 16);
        check("ovr sticky", {31'h0, overrun}, 32'h1);

        set_ch(16'hCAFE, 16'hBEEF, 16'h0FF0, 16'h7E57);
        do_conv(1'b0, 16'h0, "abt1");
        shift_bits(7);
        set_ch(16'h3C3C, 16'hC3C3, 16'h0102, 16'h8001);
        do_conv(1'b0, 16'h0, "abt2");
        shift_bits(16);
        check_frame("abort", 16);

        for (int k = 0; k < 3; k++) begin
            set_ch(16'h1111 * (k + 1), 16'h0F00 >> k,
                   16'h8001 << k, ~(16'h00FF << k));
            do_conv(1'b0, 16'h0, $sformatf("seq%0d", k));
            shift_bits(16);
            check_frame($sformatf("seq%0d", k), 16);
        end

        set_ch(16'h8421, 16'h1248, 16'hF00F, 16'h0FF0);
        do_conv(1'b0, 16'h0, "x20");
        r0 = rises;
        shift_bits(20);
        check_frame("x20", 20);
        check("x20 clkout rises", rises - r0, 20);

        set_ch(16'h6A6A, 16'h0246, 16'hFEDC, 16'h1001);
        do_conv(1'b0, 16'h0, "rst1");
        shift_bits(9);
        rst_n = 1'b0;
        #1;
        check("mid rst sdo", {28'h0, sdo}, 32'h0);
        check("mid rst clkout", {31'h0, CLKOUT}, 32'h0);
        check("mid rst busy", {31'h0, busy}, 32'h0);
        check("mid rst overrun", {31'h0, overrun}, 32'h0);
        m2 = '0;
        m3 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        set_ch(16'h5A5A, 16'hFFFE, 16'h0003, 16'h4000);
        do_conv(1'b0, 16'h0, "rst2");
        shift_bits(16);
        check_frame("rst2", 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
